boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_pkg.sv | 26 ++
 rtl/boot_sequencer_if.sv | 41 ++++
 rtl/boot_settle_cnt.sv | 37 +++
 rtl/boot_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_boot_sequencer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the boot sequencer.
// Holds the sequencer state encoding, the memory target encoding and the
// default parameter values used by the sequencer, its bus interface and the
// settle counter.
package boot_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_WDOG_W     = 16;

  // Memory target selected at segment start.
  localparam logic TGT_IMEM = 1'b0;
  localparam logic TGT_DMEM = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ARMED  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

endpackage

// File: rtl/boot_sequencer_if.sv
// Load-stream and memory-write bus of the boot sequencer.
//
// Stream (s_*): a word moves on every rising clock edge where s_valid and
// s_ready are both high. The source holds s_data/s_last stable while s_valid
// is high and s_ready is low; s_valid must not depend on s_ready. s_last
// marks the final word of a segment.
//
// Memory write (imem_we/dmem_we/mem_addr/mem_din): one write per cycle where
// a strobe is high; the two strobes are never high together.
//
// Modports:
//   slave  - the sequencer: consumes the stream, drives the memory write port
//   master - the environment: sources the stream, observes memory writes
interface boot_sequencer_if
  import boot_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  logic              imem_we;
  logic              dmem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, imem_we, dmem_we, mem_addr, mem_din
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, imem_we, dmem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/boot_settle_cnt.sv
// Loadable down-counter with a zero flag.
// Used to time the CPU settle interval and, when the watchdog is built, the
// CPU run budget. The count stops at zero instead of wrapping.
//
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-low reset (count cleared)
//   load    - load loadVal this cycle (wins over dec)
//   loadVal - value to load
//   dec     - decrement by one when non-zero
//   zero    - count is zero
module boot_settle_cnt #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: loads program/data segments from a word stream into the
// instruction or data memory, then releases the CPU from reset after a fixed
// settle interval and waits for the CPU to halt.
//
// Optional feature: define BOOT_WATCHDOG_EN to build a run watchdog that ends
// RUN with timeout=1 (CPU held in reset again) when the CPU never halts.
//
// Ports:
//   clock, reset      - clock and asynchronous active-low reset
//   start             - pulse: begin a segment at base_addr into target
//   base_addr, target - segment start address and memory (TGT_IMEM/TGT_DMEM)
//   go                - pulse: finish loading and boot the CPU
//   cpu_halt          - CPU reports it has nothing left to do
//   cpu_reset         - active-high CPU reset
//   busy, done, err, timeout - status flags
//   dbg_state         - current sequencer state
//   bus               - load stream in, memory write port out
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int WDOG_W     = DEF_WDOG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              target,
  input  logic              go,
  input  logic              cpu_halt,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              timeout,
  output state_t            dbg_state,
  boot_sequencer_if.slave   bus
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  // SETTLE lasts SETTLE_CYC cycles: the counter is loaded with SETTLE_CYC-1
  // on entry and RUN is taken in the cycle it reads zero.
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LOAD =
    (SETTLE_CYC > 1) ? SET_W'(SETTLE_CYC - 1) : '0;

  state_t            state;
  logic [ADDR_W-1:0] addrQ;
  logic              tgtQ;
  logic              sReadyQ;

  logic xfer;
  logic startAccepted;
  logic settleLoad;
  logic settleZero;
  logic runEntry;
  logic wdogZero;

  // Writes go straight from the handshake to the memory port, no buffering.
  assign xfer         = bus.s_valid & sReadyQ;
  assign bus.s_ready  = sReadyQ;
  assign bus.imem_we  = xfer & (tgtQ == TGT_IMEM);
  assign bus.dmem_we  = xfer & (tgtQ == TGT_DMEM);
  assign bus.mem_addr = xfer ? addrQ : '0;
  assign bus.mem_din  = xfer ? bus.s_data : '0;

  assign dbg_state = state;

  // start is honoured everywhere except while a segment or boot is running;
  // in ARMED it takes priority over a simultaneous go.
  assign startAccepted = start &&
    ((state == ST_IDLE) || (state == ST_ARMED) ||
     (state == ST_DONE) || (state == ST_ERROR));
  assign settleLoad = go && !start &&
    ((state == ST_IDLE) || (state == ST_ARMED));
  assign runEntry   = (state == ST_SETTLE) && settleZero;

  boot_settle_cnt #(.W(SET_W)) uSettle (
    .clock   (clock),
    .reset   (reset),
    .load    (settleLoad),
    .loadVal (SET_LOAD),
    .dec     (state == ST_SETTLE),
    .zero    (settleZero)
  );

`ifdef BOOT_WATCHDOG_EN
  // Run budget of 2^WDOG_W-1 cycles: loaded with all-ones minus one on RUN
  // entry, so the zero flag is seen in the last allowed RUN cycle.
  localparam logic [WDOG_W-1:0] WDOG_LOAD = {{(WDOG_W-1){1'b1}}, 1'b0};

  boot_settle_cnt #(.W(WDOG_W)) uWdog (
    .clock   (clock),
    .reset   (reset),
    .load    (runEntry),
    .loadVal (WDOG_LOAD),
    .dec     (state == ST_RUN),
    .zero    (wdogZero)
  );
`else
  assign wdogZero = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      addrQ     <= '0;
      tgtQ      <= TGT_IMEM;
      sReadyQ   <= 1'b0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      timeout   <= 1'b0;
    end else if (startAccepted) begin
      state     <= ST_LOAD;
      addrQ     <= base_addr;
      tgtQ      <= target;
      sReadyQ   <= 1'b1;
      cpu_reset <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            state <= ST_SETTLE;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            if (bus.s_last) begin
              state   <= ST_ARMED;
              sReadyQ <= 1'b0;
            end else if (addrQ == ADDR_MAX) begin
              // Top address written without s_last: the segment overruns.
              state   <= ST_ERROR;
              sReadyQ <= 1'b0;
              busy    <= 1'b0;
              err     <= 1'b1;
            end
            if (addrQ != ADDR_MAX) begin
              addrQ <= addrQ + 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (go) begin
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settleZero) begin
            state     <= ST_RUN;
            cpu_reset <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cpu_halt) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (wdogZero) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout   <= 1'b1;
            cpu_reset <= 1'b1;
          end
        end
        default: begin
          // DONE and ERROR hold until start.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer. Segment writes are predicted from
// the address/last rules into an expected queue and matched against the
// memory-write strobes observed on the bus; status, state and timing are
// checked against constants derived from the sequencer's rules.
// Define BOOT_WATCHDOG_EN to also exercise the run watchdog (WDOG_W=4).
module tb_boot_sequencer;
  import boot_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int SC  = 4;
`ifdef BOOT_WATCHDOG_EN
  localparam int WW       = 4;
  localparam int HALT_CYC = 10;
`else
  localparam int WW       = 16;
  localparam int HALT_CYC = 20;
`endif
  localparam int SBW = 1 + AW + DW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          target = 1'b0;
  logic          go = 1'b0;
  logic          cpu_halt = 1'b0;
  logic          cpu_reset, busy, done, err, timeout;
  state_t        dbg_state;

  boot_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  boot_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .SETTLE_CYC(SC), .WDOG_W(WW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .target    (target),
    .go        (go),
    .cpu_halt  (cpu_halt),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .timeout   (timeout),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [SBW-1:0] exp_q[$];
  logic [SBW-1:0] obs_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every write strobe seen is recorded as {is_dmem, addr, data}.
  always @(negedge clock) begin
    if (bus.imem_we || bus.dmem_we) begin
      check_eq("we_onehot", 32'(bus.imem_we & bus.dmem_we), 32'd0);
      obs_q.push_back({bus.dmem_we, bus.mem_addr, bus.mem_din});
    end
  end

  task automatic check_writes(input string tag);
    check_eq({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check_eq({tag, "_write"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic t,
                             input logic with_go);
    start     = 1'b1;
    base_addr = b;
    target    = t;
    go        = with_go;
    step();
    start = 1'b0;
    go    = 1'b0;
  endtask

  // Streams n words with random gaps. The model predicts which words land:
  // consecutive addresses from b, stopping after s_last or after the top
  // address is written without s_last (overrun).
  task automatic stream_words(input logic [AW-1:0] b, input logic t,
                              input int n, input bit with_last,
                              input bit fixed, input logic [DW-1:0] fdata,
                              output bit errored);
    int a;
    bit loading;
    logic [DW-1:0] d;
    a = int'(b);
    loading = 1'b1;
    errored = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = fixed ? fdata : DW'($urandom);
      repeat ($urandom_range(0, 2)) begin
        bus.s_valid = 1'b0;
        step();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = with_last && (i == n - 1);
      if (loading) begin
        exp_q.push_back({t, AW'(a), d});
        if (bus.s_last) begin
          loading = 1'b0;
        end else if (a == (1 << AW) - 1) begin
          loading = 1'b0;
          errored = 1'b1;
        end else begin
          a++;
        end
      end
      step();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic check_seg_end(input string tag, input bit errored);
    check_eq({tag, "_state"}, 32'(dbg_state),
             errored ? 32'(ST_ERROR) : 32'(ST_ARMED));
    check_eq({tag, "_err"}, 32'(err), 32'(errored));
    check_eq({tag, "_busy"}, 32'(busy), 32'(!errored));
    check_eq({tag, "_sready"}, 32'(bus.s_ready), 32'd0);
  endtask

  task automatic run_segment(input string tag, input logic [AW-1:0] b,
                             input logic t, input int n, input bit with_last,
                             input bit fixed, input logic [DW-1:0] fdata,
                             input logic with_go);
    bit errored;
    pulse_start(b, t, with_go);
    check_eq({tag, "_load_state"}, 32'(dbg_state), 32'(ST_LOAD));
    check_eq({tag, "_load_cpurst"}, 32'(cpu_reset), 32'd1);
    stream_words(b, t, n, with_last, fixed, fdata, errored);
    check_writes(tag);
    check_seg_end(tag, errored);
  endtask

  // Pulses go and measures cycles until cpu_reset falls, counting the go
  // cycle as cycle 0.
  task automatic boot_go(input string tag);
    int k;
    go = 1'b1;
    step();
    go = 1'b0;
    k = 1;
    check_eq({tag, "_settle_state"}, 32'(dbg_state), 32'(ST_SETTLE));
    while (cpu_reset && k < 50) begin
      step();
      k++;
    end
    check_eq({tag, "_settle_lat"}, 32'(k), 32'(SC + 1));
    check_eq({tag, "_run_state"}, 32'(dbg_state), 32'(ST_RUN));
    check_eq({tag, "_run_busy"}, 32'(busy), 32'd1);
  endtask

  // Already in RUN cycle 1; raise cpu_halt during RUN cycle halt_cyc.
  task automatic halt_on(input string tag, input int halt_cyc);
    repeat (halt_cyc - 1) step();
    check_eq({tag, "_run_cpurst"}, 32'(cpu_reset), 32'd0);
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_done_state"}, 32'(dbg_state), 32'(ST_DONE));
    check_eq({tag, "_done_cpurst"}, 32'(cpu_reset), 32'd0);
    check_eq({tag, "_done_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] rb;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // Reset values
    #12;
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("rst_cpurst", 32'(cpu_reset), 32'd1);
    check_eq("rst_sready", 32'(bus.s_ready), 32'd0);
    check_eq("rst_we", 32'({bus.imem_we, bus.dmem_we}), 32'd0);
    check_eq("rst_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_din", 32'(bus.mem_din), 32'd0);
    check_eq("rst_flags", 32'({busy, done, err, timeout}), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Seven fixed words into IMEM from 0x00
    run_segment("seg_imem7", 8'h00, TGT_IMEM, 7, 1'b1, 1'b1, 16'h1121, 1'b0);

    // DMEM segment at 0x10; go in the start cycle must lose to start
    run_segment("seg_dmem2", 8'h10, TGT_DMEM, 2, 1'b1, 1'b0, '0, 1'b1);

    // Random segments, biased towards the top of the address space
    for (int r = 0; r < 10; r++) begin
      rb = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(250, 255))
                                       : AW'($urandom_range(0, 255));
      run_segment("seg_rand", rb, 1'($urandom_range(0, 1)),
                  $urandom_range(1, 6), 1'b1, 1'b0, '0, 1'b0);
    end

    // Overrun: 3 words from 0xFE without s_last -> 2 writes, ERROR
    run_segment("seg_ovr", 8'hFE, TGT_IMEM, 3, 1'b0, 1'b0, '0, 1'b0);

    // go during LOAD is ignored
    pulse_start(8'h20, TGT_DMEM, 1'b0);
    go = 1'b1;
    step();
    go = 1'b0;
    check_eq("go_in_load_state", 32'(dbg_state), 32'(ST_LOAD));
    begin
      bit e;
      stream_words(8'h20, TGT_DMEM, 2, 1'b1, 1'b0, '0, e);
      check_writes("go_in_load");
      check_seg_end("go_in_load", e);
    end

    // Boot, run, halt
    boot_go("boot1");
    halt_on("boot1", HALT_CYC);
    step();
    step();
    check_eq("done_hold", 32'(done), 32'd1);

    // start from DONE re-asserts cpu_reset the following cycle
    run_segment("seg_after_done", 8'h40, TGT_IMEM, 3, 1'b1, 1'b0, '0, 1'b0);
    check_eq("after_done_flag", 32'(done), 32'd0);

    // Reset mid-LOAD with s_valid high
    pulse_start(8'h80, TGT_IMEM, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hBEEF;
    #1;
    check_eq("midrst_pre_we", 32'(bus.imem_we), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_eq("midrst_we", 32'({bus.imem_we, bus.dmem_we}), 32'd0);
    check_eq("midrst_cpurst", 32'(cpu_reset), 32'd1);
    check_eq("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("midrst_sready", 32'(bus.s_ready), 32'd0);
    bus.s_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_writes("midrst");

    // Boot straight from IDLE with no load
    boot_go("boot_idle");
`ifdef BOOT_WATCHDOG_EN
    begin
      int n_run;
      n_run = 1;
      while (dbg_state == ST_RUN && n_run < 100) begin
        step();
        if (dbg_state == ST_RUN) n_run++;
      end
      check_eq("wdog_run_cycles", 32'(n_run), 32'((1 << WW) - 1));
      check_eq("wdog_timeout", 32'(timeout), 32'd1);
      check_eq("wdog_cpurst", 32'(cpu_reset), 32'd1);
      check_eq("wdog_done", 32'(done), 32'd1);
    end
`else
    halt_on("boot_idle", 3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
